// File: rtl/ore_alu_pkg.sv
// ore_alu_pkg: shared opcode, control and state types for the ORE ALU sequencer.
package ore_alu_pkg;

  // Opcodes accepted on in_op; 0xB-0xF are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_RSB  = 4'h2,
    OP_ADC  = 4'h3,
    OP_SBC  = 4'h4,
    OP_OR   = 4'h5,
    OP_XNOR = 4'h6,
    OP_CMP  = 4'h7,
    OP_INC  = 4'h8,
    OP_DEC  = 4'h9,
    OP_CLC  = 4'hA
  } op_e;

  // Control bits of the attached ripple-carry ALU.
  typedef struct packed {
    logic inv_a;
    logic inv_b;
    logic cin;
    logic oren;
    logic flood;
  } alu_ctrl_t;

  // Sequencer phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Source of the ALU B operand.
  typedef enum logic [1:0] {
    BSEL_B    = 2'd0,
    BSEL_ZERO = 2'd1,
    BSEL_ONES = 2'd2
  } bsel_e;

  // Which architectural flags an op writes; clr_c forces C to zero.
  typedef struct packed {
    logic upd_c;
    logic upd_z;
    logic upd_v;
    logic clr_c;
  } flag_upd_t;

  localparam alu_ctrl_t CTRL_NONE = 5'b00000;
  localparam alu_ctrl_t CTRL_SUB  = 5'b01100;
  localparam alu_ctrl_t CTRL_RSB  = 5'b10100;
  localparam alu_ctrl_t CTRL_OR   = 5'b00010;
  localparam alu_ctrl_t CTRL_XNOR = 5'b00001;
  localparam alu_ctrl_t CTRL_INC  = 5'b00100;

  localparam flag_upd_t FUPD_NONE  = 4'b0000;
  localparam flag_upd_t FUPD_ARITH = 4'b1110;
  localparam flag_upd_t FUPD_LOGIC = 4'b0100;
  localparam flag_upd_t FUPD_CLC   = 4'b0001;

  // Flag-update class of each opcode.
  function automatic flag_upd_t flag_class(input logic [3:0] op);
    flag_upd_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC,
      OP_CMP, OP_INC, OP_DEC:                 cls = FUPD_ARITH;
      OP_OR, OP_XNOR:                         cls = FUPD_LOGIC;
      OP_CLC:                                 cls = FUPD_CLC;
      default:                                cls = FUPD_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ore_alu_decode.sv
// ore_alu_decode: combinational opcode decode into ALU controls, B-select,
// flag-update class and the illegal-opcode indication.
module ore_alu_decode
  import ore_alu_pkg::*;
(
  input  logic      [3:0] op_i,
  input  logic            flag_c_i,
  output alu_ctrl_t       ctrl_o,
  output bsel_e           bsel_o,
  output flag_upd_t       fupd_o,
  output logic            use_alu_o,
  output logic            illegal_o
);

  // Opcode to ALU control table; ADC/SBC feed the carry flag into cin.
  always_comb begin
    ctrl_o    = CTRL_NONE;
    bsel_o    = BSEL_B;
    use_alu_o = 1'b1;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:         ctrl_o = CTRL_NONE;
      OP_SUB, OP_CMP: ctrl_o = CTRL_SUB;
      OP_RSB:         ctrl_o = CTRL_RSB;
      OP_ADC: begin
        ctrl_o     = CTRL_NONE;
        ctrl_o.cin = flag_c_i;
      end
      OP_SBC: begin
        ctrl_o       = CTRL_NONE;
        ctrl_o.inv_b = 1'b1;
        ctrl_o.cin   = flag_c_i;
      end
      OP_OR:          ctrl_o = CTRL_OR;
      OP_XNOR:        ctrl_o = CTRL_XNOR;
      OP_INC: begin
        ctrl_o = CTRL_INC;
        bsel_o = BSEL_ZERO;
      end
      OP_DEC: begin
        ctrl_o = CTRL_NONE;
        bsel_o = BSEL_ONES;
      end
      OP_CLC: begin
        use_alu_o = 1'b0;
        bsel_o    = BSEL_ZERO;
      end
      default: begin
        use_alu_o = 1'b0;
        illegal_o = 1'b1;
        bsel_o    = BSEL_ZERO;
      end
    endcase
  end

  assign fupd_o = flag_class(op_i);

endmodule

// File: rtl/ore_alu_sequencer.sv
// ore_alu_sequencer: issue/retire stage around an externally attached ORE ALU.
// Accepts one op in IDLE, drives the ALU for one EXEC cycle, then holds the
// registered result and flags in DONE until the consumer takes them.
module ore_alu_sequencer
  import ore_alu_pkg::*;
#(
  parameter int BitWidth = 8
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [BitWidth-1:0] in_a,
  input  logic [BitWidth-1:0] in_b,
  output logic                alu_inv_a,
  output logic                alu_inv_b,
  output logic                alu_cin,
  output logic                alu_oren,
  output logic                alu_flood,
  output logic [BitWidth-1:0] alu_a,
  output logic [BitWidth-1:0] alu_b,
  input  logic [BitWidth-1:0] alu_dout,
  input  logic                alu_cout,
  input  logic                alu_zero,
  input  logic                alu_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BitWidth-1:0] out_data,
  output logic                flag_c,
  output logic                flag_z,
  output logic                flag_v,
  output logic                out_err
);

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [BitWidth-1:0] out_data_q;
  logic                flag_c_q;
  logic                flag_z_q;
  logic                flag_v_q;
  logic                err_q;
  alu_ctrl_t           ctrl_q;
  logic [BitWidth-1:0] alu_a_q;
  logic [BitWidth-1:0] alu_b_q;
  flag_upd_t           fupd_q;
  logic                use_alu_q;
  logic                illegal_q;

  alu_ctrl_t           dec_ctrl_s;
  bsel_e               dec_bsel_s;
  flag_upd_t           dec_fupd_s;
  logic                dec_use_alu_s;
  logic                dec_illegal_s;
  logic [BitWidth-1:0] alu_a_d;
  logic [BitWidth-1:0] alu_b_d;

  // Decode the incoming opcode; carry is the current flag, which cannot change
  // between acceptance and EXEC.
  ore_alu_decode u_decode (
    .op_i      (in_op),
    .flag_c_i  (flag_c_q),
    .ctrl_o    (dec_ctrl_s),
    .bsel_o    (dec_bsel_s),
    .fupd_o    (dec_fupd_s),
    .use_alu_o (dec_use_alu_s),
    .illegal_o (dec_illegal_s)
  );

  // Operand values presented to the ALU; zero when the op does not use it.
  always_comb begin
    alu_a_d = {BitWidth{1'b0}};
    alu_b_d = {BitWidth{1'b0}};
    if (dec_use_alu_s) begin
      alu_a_d = in_a;
      case (dec_bsel_s)
        BSEL_B:    alu_b_d = in_b;
        BSEL_ZERO: alu_b_d = {BitWidth{1'b0}};
        BSEL_ONES: alu_b_d = {BitWidth{1'b1}};
        default:   alu_b_d = {BitWidth{1'b0}};
      endcase
    end else begin
      alu_a_d = {BitWidth{1'b0}};
      alu_b_d = {BitWidth{1'b0}};
    end
  end

  // Sequencer FSM with all outputs, ALU drive and flags held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {BitWidth{1'b0}};
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      err_q       <= 1'b0;
      ctrl_q      <= CTRL_NONE;
      alu_a_q     <= {BitWidth{1'b0}};
      alu_b_q     <= {BitWidth{1'b0}};
      fupd_q      <= FUPD_NONE;
      use_alu_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= EXEC;
            in_ready_q <= 1'b0;
            ctrl_q     <= dec_use_alu_s ? dec_ctrl_s : CTRL_NONE;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            fupd_q     <= dec_fupd_s;
            use_alu_q  <= dec_use_alu_s;
            illegal_q  <= dec_illegal_s;
          end
        end
        EXEC: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          ctrl_q      <= CTRL_NONE;
          alu_a_q     <= {BitWidth{1'b0}};
          alu_b_q     <= {BitWidth{1'b0}};
          out_data_q  <= use_alu_q ? alu_dout : {BitWidth{1'b0}};
          err_q       <= illegal_q;
          if (fupd_q.clr_c) begin
            flag_c_q <= 1'b0;
          end else if (fupd_q.upd_c) begin
            flag_c_q <= alu_cout;
          end
          if (fupd_q.upd_z) begin
            flag_z_q <= alu_zero;
          end
          if (fupd_q.upd_v) begin
            flag_v_q <= alu_ovf;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          ctrl_q      <= CTRL_NONE;
          alu_a_q     <= {BitWidth{1'b0}};
          alu_b_q     <= {BitWidth{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
  assign out_err   = err_q;
  assign alu_inv_a = ctrl_q.inv_a;
  assign alu_inv_b = ctrl_q.inv_b;
  assign alu_cin   = ctrl_q.cin;
  assign alu_oren  = ctrl_q.oren;
  assign alu_flood = ctrl_q.flood;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_ore_alu_sequencer.sv
// Self-checking bench for ore_alu_sequencer with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_ore_alu_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'h0;
  logic [W-1:0] in_a = 8'h00;
  logic [W-1:0] in_b = 8'h00;
  logic         alu_inv_a, alu_inv_b, alu_cin, alu_oren, alu_flood;
  logic [W-1:0] alu_a, alu_b, alu_dout;
  logic         alu_cout, alu_zero, alu_ovf;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flag_c, flag_z, flag_v, out_err;

  int checks = 0;
  int errors = 0;

  ore_alu_sequencer #(.BitWidth(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_inv_a(alu_inv_a), .alu_inv_b(alu_inv_b), .alu_cin(alu_cin),
    .alu_oren(alu_oren), .alu_flood(alu_flood), .alu_a(alu_a), .alu_b(alu_b),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ORE ALU: optional inversion, then OR, flooded-carry XNOR or add.
  logic [W-1:0] opa, opb;
  logic [W:0]   asum;
  always_comb begin
    opa  = alu_inv_a ? ~alu_a : alu_a;
    opb  = alu_inv_b ? ~alu_b : alu_b;
    asum = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, alu_cin};
    if (alu_oren) begin
      alu_dout = opa | opb;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
    end else if (alu_flood) begin
      alu_dout = ~(opa ^ opb);
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
    end else begin
      alu_dout = asum[W-1:0];
      alu_cout = asum[W];
      alu_ovf  = (opa[W-1] == opb[W-1]) && (asum[W-1] != opa[W-1]);
    end
    alu_zero = (alu_dout == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one op, written with plain integer arithmetic.
  typedef struct packed {
    logic [7:0] data;
    logic c, z, v, err;
  } res_t;

  function automatic res_t calc(input int op, input int a, input int b,
                                input bit c, input bit z, input bit v);
    res_t r;
    int sa, sb, s, sv;
    bit arith;
    r.data = 8'h00; r.c = c; r.z = z; r.v = v; r.err = 1'b0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    arith = 1'b1; s = 0; sv = 0;
    case (op)
      0:    begin s = a + b;         r.c = (s > 255);               sv = sa + sb;         end
      1, 7: begin s = a - b;         r.c = (a >= b);                sv = sa - sb;         end
      2:    begin s = b - a;         r.c = (b >= a);                sv = sb - sa;         end
      3:    begin s = a + b + int'(c); r.c = (s > 255);             sv = sa + sb + int'(c); end
      4:    begin s = a - b - 1 + int'(c); r.c = (a + int'(c) > b); sv = sa - sb - 1 + int'(c); end
      8:    begin s = a + 1;         r.c = (a == 255);              sv = sa + 1;          end
      9:    begin s = a - 1;         r.c = (a != 0);                sv = sa - 1;          end
      5:    begin arith = 1'b0; r.data = 8'(a | b);    r.z = (r.data == 8'h00); end
      6:    begin arith = 1'b0; r.data = 8'(~(a ^ b)); r.z = (r.data == 8'h00); end
      10:   begin arith = 1'b0; r.data = 8'h00; r.c = 1'b0; end
      default: begin arith = 1'b0; r.data = 8'h00; r.err = 1'b1; end
    endcase
    if (arith) begin
      r.data = 8'(s & 255);
      r.z    = (r.data == 8'h00);
      r.v    = (sv > 127) || (sv < -128);
    end
    return r;
  endfunction

  function automatic logic [4:0] exp_ctrl(input int op, input bit c);
    case (op)
      1, 7:    return 5'b01100;
      2:       return 5'b10100;
      3:       return {2'b00, c, 2'b00};
      4:       return {2'b01, c, 2'b00};
      5:       return 5'b00010;
      6:       return 5'b00001;
      8:       return 5'b00100;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic int exp_a(input int op, input int a);
    return (op <= 9) ? a : 0;
  endfunction

  function automatic int exp_b(input int op, input int b);
    if (op == 8) return 0;
    if (op == 9) return 255;
    return (op <= 9) ? b : 0;
  endfunction

  // Transaction model: phase 0 waiting, 1 executing, 2 holding the result.
  int         m_phase, m_op, m_a, m_b;
  logic [7:0] m_data;
  bit         m_c, m_z, m_v, m_err;
  res_t       m_next;
  always_comb m_next = calc(m_op, m_a, m_b, m_c, m_z, m_v);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_op <= 0; m_a <= 0; m_b <= 0; m_data <= 8'h00;
      m_c <= 1'b0; m_z <= 1'b0; m_v <= 1'b0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_op <= int'(in_op); m_a <= int'(in_a); m_b <= int'(in_b); m_phase <= 1;
        end
        1: begin
          m_data <= m_next.data; m_c <= m_next.c; m_z <= m_next.z;
          m_v <= m_next.v; m_err <= m_next.err; m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("flags_czv", 32'({flag_c, flag_z, flag_v}), 32'({m_c, m_z, m_v}));
      chk("out_err", 32'(out_err), 32'(m_err));
      if (m_phase == 1) begin
        chk("exec_ctrl", 32'({alu_inv_a, alu_inv_b, alu_cin, alu_oren, alu_flood}),
            32'(exp_ctrl(m_op, m_c)));
        chk("exec_a", 32'(alu_a), 32'(exp_a(m_op, m_a)));
        chk("exec_b", 32'(alu_b), 32'(exp_b(m_op, m_b)));
      end else if (m_phase == 0) begin
        chk("idle_drive", 32'({alu_inv_a, alu_inv_b, alu_cin, alu_oren, alu_flood, alu_a, alu_b}), 32'd0);
      end
    end
  end

  logic [4:0]   exec_ctrl;
  logic [W-1:0] exec_b;

  // Present one op, check the EXEC-to-DONE latency and leave the result held.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0; in_op = 4'h0; in_a = 8'h00; in_b = 8'h00;
    @(negedge clk);
    exec_ctrl = {alu_inv_a, alu_inv_b, alu_cin, alu_oren, alu_flood};
    exec_b    = alu_b;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd2);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic lit(input string name, input logic [7:0] d, input logic c,
                     input logic z, input logic v, input logic e);
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_czv"}, 32'({flag_c, flag_z, flag_v}), 32'({c, z, v}));
    chk({name, "_err"}, 32'(out_err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    lit("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow into the sign bit.
    run_op(4'h0, 8'h7F, 8'h01); lit("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0); pop();
    run_op(4'h1, 8'h05, 8'h05); lit("sub_eq", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sub_ctrl", 32'(exec_ctrl), 32'h0C); pop();
    run_op(4'h7, 8'h03, 8'h05); lit("cmp", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0); pop();

    // Carry chain, and CLC breaking it.
    run_op(4'h0, 8'hFF, 8'h01); lit("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); pop();
    run_op(4'h3, 8'h00, 8'h00); lit("adc_c1", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("adc_ctrl", 32'(exec_ctrl), 32'h04); pop();
    run_op(4'h0, 8'hFF, 8'h01); pop();
    run_op(4'hA, 8'h12, 8'h34); lit("clc", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); pop();
    run_op(4'h3, 8'h00, 8'h00); lit("adc_c0", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); pop();

    // Remaining arithmetic and logic ops.
    run_op(4'h2, 8'h10, 8'h30); lit("rsb", 8'h20, 1'b1, 1'b0, 1'b0, 1'b0); pop();
    run_op(4'h4, 8'h50, 8'h10); lit("sbc", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0); pop();
    run_op(4'h8, 8'h7F, 8'hAA); lit("inc", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("inc_ctrl", 32'(exec_ctrl), 32'h04); chk("inc_b", 32'(exec_b), 32'h00); pop();
    run_op(4'h5, 8'h0F, 8'hF0); lit("or", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0); pop();
    run_op(4'h6, 8'hA5, 8'h5A); lit("xnor", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0); pop();
    run_op(4'h9, 8'h00, 8'h55); lit("dec", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dec_b", 32'(exec_b), 32'hFF); pop();

    // Backpressure: result held, new requests ignored.
    run_op(4'h0, 8'h12, 8'h34);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 4'h1; in_a = 8'hAA; in_b = 8'h11;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      lit("bp_hold", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    pop();
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Illegal opcode keeps flags; the next legal op clears out_err.
    run_op(4'h0, 8'h80, 8'hFF); lit("add_80_ff", 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0); pop();
    run_op(4'hC, 8'h33, 8'h44); lit("illegal", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("illegal_ctrl", 32'(exec_ctrl), 32'd0); pop();
    run_op(4'h0, 8'h01, 8'h01); lit("add_after_err", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0); pop();

    // Asynchronous reset in EXEC drops the op and the carry.
    run_op(4'h0, 8'h80, 8'hFF); pop();
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'h1; in_a = 8'h10; in_b = 8'h01;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_drive", 32'({alu_inv_b, alu_cin, alu_a}), 32'd0);
    lit("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    run_op(4'h3, 8'h00, 8'h00); lit("adc_after_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); pop();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ore_alu_sequencer.md
Name: ore_alu_sequencer

Overview:
Issue and retire stage wrapped around the ORE-style ripple-carry ALU, which is instantiated by the parent.
- Accepts {opcode, A, B} over a valid/ready handshake and decodes the opcode into the ALU control bits (InvA, InvB, cIn, ORen, FloodCarry).
- Drives the ALU operands for one cycle, then registers dOUT and the flags.
- Keeps a persistent carry flag for ADC/SBC chaining and presents the result over a valid/ready output handshake.

Parameters:
- BitWidth, 8: datapath width; must match the attached ALU; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_op  in  4  opcode (ore_alu_pkg::op_e).
- in_a  in  BitWidth  operand A.
- in_b  in  BitWidth  operand B.
- alu_inv_a, alu_inv_b, alu_cin, alu_oren, alu_flood  out  1 each  control bits to the ALU.
- alu_a, alu_b  out  BitWidth each  operands to the ALU.
- alu_dout  in  BitWidth  ALU result.
- alu_cout, alu_zero, alu_ovf  in  1 each  ALU flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  BitWidth  registered result.
- flag_c, flag_z, flag_v  out  1 each  architectural flag register.
- out_err  out  1  last retired op had an illegal opcode.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
  - Reset values: state=IDLE; in_ready=1; out_valid=0; out_data=0; flags C/Z/V=0; out_err=0.
  - ALU drive outputs are 0 while in IDLE.
- FSM IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid, capture op/A/B and go to EXEC.
  - EXEC: in_ready=0. Drive decoded control bits and the captured operands. At the clock edge, capture alu_dout into out_data, update the flags per the op, and go to DONE.
  - DONE: out_valid=1; out_data, flags and out_err are stable. When out_ready=1, go to IDLE.
- No bypass: in_ready is 0 during DONE even if out_ready=1 in that cycle. Throughput is one op per 3 cycles; latency from acceptance edge to out_valid is 2 cycles.
- Decode, as {inv_a, inv_b, cin, oren, flood}, alu_a, alu_b:
  - ADD 0x0: 00000, A, B.
  - SUB 0x1: 01100, A, B.
  - RSB 0x2: 10100, A, B.
  - ADC 0x3: 0,0,C,0,0, A, B.
  - SBC 0x4: 0,1,C,0,0, A, B.
  - OR 0x5: 00010, A, B.
  - XNOR 0x6: 00001, A, B.
  - CMP 0x7: as SUB; out_data holds the SUB result.
  - INC 0x8: 00100, A, 0.
  - DEC 0x9: 00000, A, all-ones.
  - CLC 0xA: no ALU use; out_data=0; C=0; Z and V unchanged.
  - C in ADC/SBC is the flag value at EXEC.
- Flag update: arithmetic ops 0x0-0x4, 0x7, 0x8, 0x9 load C=alu_cout, Z=alu_zero, V=alu_ovf. OR and XNOR load Z only.
- Illegal opcodes 0xB-0xF: ALU drive outputs stay 0, out_data=0, flags unchanged, out_err=1. out_err=0 for legal ops.
- Reset mid-operation (EXEC or DONE): the transaction is dropped with no output, all state returns to reset values, and the carry chain is lost.
- in_valid, in_op, in_a and in_b are ignored outside IDLE; operands are captured only at acceptance.

Decomposition:
- ore_alu_pkg holds:
  - op_e, a 4-bit enum with the codes above;
  - alu_ctrl_t, a packed struct {inv_a, inv_b, cin, oren, flood};
  - state_e {IDLE, EXEC, DONE};
  - flag-update class bits per op.
- One combinational sub-module, ore_alu_decode: (op, flag_c) -> alu_ctrl_t, B-select, flag-update mask, illegal bit.

Test Plan:
1. BitWidth=8, ADD A=0x7F B=0x01 -> out_valid 2 cycles after acceptance; out_data=0x80, C=0, Z=0, V=1.
2. SUB 0x05-0x05 -> 0x00, Z=1, C=1; then CMP 0x03,0x05 -> out_data=0xFE, C=0, Z=0.
3. Carry chain: ADD 0xFF+0x01 -> 0x00, C=1; then ADC 0x00+0x00 -> 0x01, C=0; then CLC, then ADC 0x00+0x00 -> 0x00.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and flags stable, in_ready=0, a new in_valid is not accepted; release -> IDLE one cycle later.
5. Reset asserted in EXEC (asynchronously, mid-cycle) -> out_valid=0 and flags 0 immediately; the next op executes normally.
6. Opcode 0xC with flags C=1/Z=0/V=1 -> out_err=1, out_data=0x00, flags unchanged; a following ADD clears out_err.
